// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch with a 2-entry {instr,pc} buffer,
// one outstanding imem request, and redirect flush/drain handling.
// Ports: clk, rst (async, active-high); imem_req/imem_addr/imem_ack/
// imem_rdata to instruction memory; instr_valid/instr_ready/instr/
// instr_pc toward decode; redirect_valid/redirect_pc from branch unit;
// misalign_err sticky flag. Define IFETCH_PERF_CNT_EN to add the
// fetch_count and stall_count outputs.
module ifetch_unit #(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         misalign_err
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]  fetch_count,
  output logic [31:0]  stall_count
`endif
);

  typedef enum logic {
    FETCH,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0] pc;
  logic [N-1:0] hold_addr;
  logic [N-1:0] fdata [2];
  logic [N-1:0] fpc   [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;

  logic ack_ok;
  logic push;
  logic pop;

  // A redirect hides the head in the same cycle, so no pop
  // can slip through alongside a flush.
  assign instr_valid = (count != 2'd0) && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign instr       = fdata[rd_ptr];
  assign instr_pc    = fpc[rd_ptr];

  // An ack only counts against a live request.
  assign ack_ok = imem_req && imem_ack;
  assign push   = ack_ok && (state == FETCH) && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Once asserted in FETCH the request cannot drop: occupancy only
  // falls until the ack, and a redirect moves the request to DRAIN
  // where hold_addr keeps the old address on the bus.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    imem_addr = {pc[N-1:2], 2'b00};
    unique case (state)
      FETCH: begin
        imem_req = !rst && ((count != 2'd2) || pop);
        if (redirect_valid && imem_req && !imem_ack)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        imem_req  = !rst;
        imem_addr = hold_addr;
        if (imem_ack)
          state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      hold_addr <= '0;
    end else begin
      if (state == FETCH && state_nxt == DRAIN)
        hold_addr <= imem_addr;
      if (redirect_valid)
        pc <= {redirect_pc[N-1:2], 2'b00};
      else if (push)
        pc <= pc + N'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fdata[0] <= '0;
      fdata[1] <= '0;
      fpc[0]   <= '0;
      fpc[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fdata[wr_ptr] <= imem_rdata;
        fpc[wr_ptr]   <= imem_addr;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign_err <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
      misalign_err <= 1'b1;
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push)
        fetch_count <= fetch_count + 32'd1;
      if (imem_req && !imem_ack)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed cycle vectors for ifetch_unit.
// Memory returns addr ^ 32'h5A5A_A5A5 as the instruction word.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  ifetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .misalign_err  (misalign_err)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] KEY = 32'h5A5A_A5A5;
  assign imem_rdata = imem_addr ^ KEY;

  int errors = 0;
  int checks = 0;
  int exp_fetch = 0;
  int exp_stall = 0;

  typedef struct {
    bit          rs;
    bit          ack;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    int          rep;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] ipc;
    bit          mis;
    bit          acc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    bit rs, bit ack, bit rdy, bit rv,
    logic [31:0] rpc, int rep,
    bit req, logic [31:0] addr,
    bit vld, logic [31:0] ipc,
    bit mis, bit acc);
    vec_t t;
    t.rs = rs; t.ack = ack; t.rdy = rdy;
    t.rv = rv; t.rpc = rpc; t.rep = rep;
    t.req = req; t.addr = addr;
    t.vld = vld; t.ipc = ipc;
    t.mis = mis; t.acc = acc;
    return t;
  endfunction

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step(vec_t t, int idx);
    rst            = t.rs;
    imem_ack       = t.ack;
    instr_ready    = t.rdy;
    redirect_valid = t.rv;
    redirect_pc    = t.rpc;
    for (int r = 0; r < t.rep; r++) begin
      #1;
      chk($sformatf("req[%0d.%0d]", idx, r),
          {31'b0, imem_req}, {31'b0, t.req});
      if (t.req)
        chk($sformatf("addr[%0d.%0d]", idx, r),
            imem_addr, t.addr);
      chk($sformatf("valid[%0d.%0d]", idx, r),
          {31'b0, instr_valid}, {31'b0, t.vld});
      if (t.vld) begin
        chk($sformatf("ipc[%0d.%0d]", idx, r),
            instr_pc, t.ipc);
        chk($sformatf("instr[%0d.%0d]", idx, r),
            instr, t.ipc ^ KEY);
      end
      if (t.rs) begin
        chk($sformatf("rst_instr[%0d]", idx),
            instr, 32'h0);
        chk($sformatf("rst_ipc[%0d]", idx),
            instr_pc, 32'h0);
      end
      chk($sformatf("mis[%0d.%0d]", idx, r),
          {31'b0, misalign_err}, {31'b0, t.mis});
      if (t.rs) begin
        exp_fetch = 0;
        exp_stall = 0;
      end else begin
        if (t.acc) exp_fetch++;
        if (t.req && !t.ack) exp_stall++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic chk_cnt(string tag);
`ifdef IFETCH_PERF_CNT_EN
    chk({tag, "_fetch_count"}, fetch_count, exp_fetch);
    chk({tag, "_stall_count"}, stall_count, exp_stall);
`else
    if (tag.len() == 0) $display("no counters");
`endif
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;

    //       rs a r rv rpc    rep req addr    v ipc    m acc
    // streaming, zero-wait memory
    tbl.push_back(v(1,0,0,0,0,     1, 0,0,     0,0,     0,0));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'h0, 0,0,     0,1));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'h4, 1,32'h0, 0,1));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'h8, 1,32'h4, 0,1));
    // backpressure: two entries buffered, stray acks ignored
    tbl.push_back(v(1,0,0,0,0,     1, 0,0,     0,0,     0,0));
    tbl.push_back(v(0,1,0,0,0,     1, 1,32'h0, 0,0,     0,1));
    tbl.push_back(v(0,1,0,0,0,     1, 1,32'h4, 1,32'h0, 0,1));
    tbl.push_back(v(0,1,0,0,0,    10, 0,0,     1,32'h0, 0,0));
    tbl.push_back(v(0,0,1,0,0,     1, 1,32'h8, 1,32'h0, 0,0));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'h8, 1,32'h4, 0,1));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'hC, 1,32'h8, 0,1));
    tbl.push_back(v(0,0,1,0,0,     1, 1,32'h10,1,32'hC, 0,0));
    tbl.push_back(v(0,0,1,0,0,     1, 1,32'h10,0,0,     0,0));
    // redirect to 0x100 during a 3-wait request to 0x8
    tbl.push_back(v(1,0,0,0,0,     1, 0,0,     0,0,     0,0));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'h0, 0,0,     0,1));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'h4, 1,32'h0, 0,1));
    tbl.push_back(v(0,0,1,0,0,     1, 1,32'h8, 1,32'h4, 0,0));
    tbl.push_back(v(0,0,1,1,32'h100,1,1,32'h8, 0,0,     0,0));
    tbl.push_back(v(0,0,1,0,0,     1, 1,32'h8, 0,0,     0,0));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'h8, 0,0,     0,0));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'h100,0,0,    0,1));
    tbl.push_back(v(0,0,1,0,0,     1, 1,32'h104,1,32'h100,0,0));
    // redirect coinciding with ack, target 0x40
    tbl.push_back(v(0,1,1,1,32'h40,1, 1,32'h104,0,0,    0,0));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'h40,0,0,     0,1));
    tbl.push_back(v(0,0,1,0,0,     1, 1,32'h44,1,32'h40,0,0));
    // two redirects while draining: last one wins
    tbl.push_back(v(0,0,1,1,32'h200,1,1,32'h44,0,0,     0,0));
    tbl.push_back(v(0,0,1,1,32'h300,1,1,32'h44,0,0,     0,0));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'h44,0,0,     0,0));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'h300,0,0,    0,1));
    // flush of a full buffer
    tbl.push_back(v(0,1,0,0,0,     1, 1,32'h304,1,32'h300,0,1));
    tbl.push_back(v(0,0,0,0,0,     1, 0,0,     1,32'h300,0,0));
    tbl.push_back(v(0,0,1,1,32'h80,1, 0,0,     0,0,     0,0));
    tbl.push_back(v(0,1,1,0,0,     1, 1,32'h80,0,0,     0,1));
    tbl.push_back(v(0,0,1,0,0,     1, 1,32'h84,1,32'h80,0,0));

    @(negedge clk);
    foreach (tbl[i]) step(tbl[i], i);
    chk_cnt("table");

    // misaligned redirect, then address wrap at the top
    step(v(1,0,0,0,0,       1,0,0,      0,0,      0,0), 100);
    step(v(0,0,1,1,32'h103, 1,1,32'h0,  0,0,      0,0), 101);
    step(v(0,1,1,0,0,       1,1,32'h0,  0,0,      1,0), 102);
    step(v(0,1,1,0,0,       1,1,32'h100,0,0,      1,1), 103);
    step(v(0,0,1,0,0,       1,1,32'h104,1,32'h100,1,0), 104);
    step(v(0,0,1,0,0,       2,1,32'h104,0,0,      1,0), 105);
    step(v(0,1,1,1,32'hFFFF_FFFC,
                            1,1,32'h104,0,0,      1,0), 106);
    step(v(0,1,1,0,0,       1,1,32'hFFFF_FFFC,0,0,1,1), 107);
    step(v(0,0,1,0,0,       1,1,32'h0,1,32'hFFFF_FFFC,1,0), 108);
    chk_cnt("wrap");
    step(v(1,0,0,0,0,       1,0,0,      0,0,      0,0), 109);
    chk_cnt("reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
